// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer plus an independent debounce FSM per active-low push button.
// Optional feature: define KEY_AUTOREPEAT_EN to auto-repeat key_press_pulse while a key stays held.
module key_debounce #(
   parameter int NUM_KEYS        = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic                MAX10_CLK1_50,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] KEY,
   output logic [NUM_KEYS-1:0] key_pressed,
   output logic [NUM_KEYS-1:0] key_press_pulse,
   output logic [NUM_KEYS-1:0] key_release_pulse
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      RELEASE_WAIT
   } state_t;

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
      $error("key_debounce: DEBOUNCE_CYCLES must be >= 2 and REPEAT_* must be >= 1");
   end

   logic [NUM_KEYS-1:0] sync_1;
   logic [NUM_KEYS-1:0] sync_2;

   // NOTE: the reset value is 1 (released), so a key held through reset is never seen as pressed
   // until it has been re-debounced from IDLE.
   always_ff @(posedge MAX10_CLK1_50) begin
      if (!rst_n) begin
         sync_1 <= '1;
         sync_2 <= '1;
      end else begin
         sync_1 <= KEY;
         sync_2 <= sync_1;
      end
   end

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
      state_t           state;
      logic [CNT_W-1:0] count;
      logic             s;
      logic             pressed;
      logic             press_p;
      logic             release_p;

`ifdef KEY_AUTOREPEAT_EN
      localparam int               RPT_W      = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
      localparam logic [RPT_W-1:0] RPT_FIRST  = RPT_W'(REPEAT_DELAY - 1);
      localparam logic [RPT_W-1:0] RPT_WRAP   = RPT_W'(REPEAT_DELAY + REPEAT_PERIOD - 1);
      localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY);
      logic [RPT_W-1:0] rpt;
`endif

      assign s = ~sync_2[i];

      assign key_pressed[i]       = pressed;
      assign key_press_pulse[i]   = press_p;
      assign key_release_pulse[i] = release_p;

      always_ff @(posedge MAX10_CLK1_50) begin
         if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            pressed   <= 1'b0;
            press_p   <= 1'b0;
            release_p <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rpt       <= '0;
`endif
         end else begin
            press_p   <= 1'b0;
            release_p <= 1'b0;
            case (state)
               IDLE: begin
                  if (s) begin
                     state <= PRESS_WAIT;
                     count <= '0;
                  end
               end
               PRESS_WAIT: begin
                  if (!s) begin
                     state <= IDLE;
                  end else if (count == CNT_LAST) begin
                     state   <= HELD;
                     pressed <= 1'b1;
                     press_p <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                     rpt     <= '0;
`endif
                  end else begin
                     count <= count + 1'b1;
                  end
               end
               HELD: begin
                  if (!s) begin
                     state <= RELEASE_WAIT;
                     count <= '0;
                  end
`ifdef KEY_AUTOREPEAT_EN
                  // Counter wraps back to REPEAT_DELAY so it stays bounded while held indefinitely.
                  else if (rpt == RPT_WRAP) begin
                     rpt     <= RPT_RELOAD;
                     press_p <= 1'b1;
                  end else begin
                     rpt <= rpt + 1'b1;
                     if (rpt == RPT_FIRST) begin
                        press_p <= 1'b1;
                     end
                  end
`endif
               end
               RELEASE_WAIT: begin
                  if (s) begin
                     state <= HELD;
                  end else if (count == CNT_LAST) begin
                     state     <= IDLE;
                     pressed   <= 1'b0;
                     release_p <= 1'b1;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter NUM_KEYS, default 2: number of independent push-button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: stable-level cycles required to accept a change (20 ms at 50 MHz); legal range 2 or more.
REQ-003 Parameter REPEAT_DELAY, default 25000000: held cycles before the first auto-repeat pulse; used only with KEY_AUTOREPEAT_EN.
REQ-004 Parameter REPEAT_PERIOD, default 5000000: cycles between subsequent auto-repeat pulses; used only with KEY_AUTOREPEAT_EN.
REQ-005 MAX10_CLK1_50  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 KEY  input  NUM_KEYS  raw board buttons, asynchronous, active-low (0 = pressed).
REQ-008 key_pressed  output  NUM_KEYS  debounced level, active-high, registered.
REQ-009 key_press_pulse  output  NUM_KEYS  one-cycle pulse per accepted press (and per auto-repeat).
REQ-010 key_release_pulse  output  NUM_KEYS  one-cycle pulse per accepted release.

Function
REQ-011 Each KEY bit SHALL pass a 2-flop synchronizer; s = inverted second-flop output (1 = pressed).
REQ-012 Each channel SHALL own an independent FSM {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} and counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-013 IDLE: s=1 -> PRESS_WAIT, counter cleared to 0; else stay.
REQ-014 PRESS_WAIT: s=0 -> IDLE; s=1 and counter = DEBOUNCE_CYCLES-1 -> HELD; else counter increments.
REQ-015 HELD: s=0 -> RELEASE_WAIT, counter cleared to 0; else stay.
REQ-016 RELEASE_WAIT: s=1 -> HELD (no pulse); s=0 and counter = DEBOUNCE_CYCLES-1 -> IDLE; else counter increments.
REQ-017 Transition PRESS_WAIT->HELD SHALL set key_pressed=1 and key_press_pulse=1 on the same edge; pulse lasts exactly one cycle.
REQ-018 Transition RELEASE_WAIT->IDLE SHALL clear key_pressed and set key_release_pulse=1 for exactly one cycle.
REQ-019 Latency: with KEY held low stable, key_pressed SHALL be 1 after rising edge number DEBOUNCE_CYCLES+3, counting the first edge that samples KEY low as edge 1; release latency identical.
REQ-020 Any glitch shorter than DEBOUNCE_CYCLES stable cycles SHALL produce no output change and no pulse.
REQ-021 Channels SHALL not interact; simultaneous events on several keys SHALL yield simultaneous independent pulses.
REQ-022 key_press_pulse and key_release_pulse of one channel SHALL never be 1 in the same cycle.

Reset
REQ-023 rst_n=0 at a rising edge SHALL load synchronizer flops with 1 (released), all FSMs IDLE, counters 0, all outputs 0.
REQ-024 Reset asserted mid-debounce or while HELD SHALL abort without emitting any pulse; a key still held after reset release SHALL be re-debounced per REQ-019 and then produce one press pulse.

Configuration
REQ-025 Macro KEY_AUTOREPEAT_EN defined: a per-channel repeat counter SHALL clear on PRESS_WAIT->HELD, increment only in HELD, freeze in RELEASE_WAIT, and emit key_press_pulse when reaching REPEAT_DELAY, then every REPEAT_PERIOD cycles while held.
REQ-026 Macro KEY_AUTOREPEAT_EN undefined: no repeat counter SHALL be synthesised; exactly one key_press_pulse per accepted press; REPEAT_* parameters ignored.

Verification (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-027 Reset: rst_n=0 for 3 cycles, KEY=2'b00 -> all outputs 0 throughout; after release, key_pressed=2'b11 at edge 11 with one press pulse each.
REQ-028 Clean press: KEY[0] low from edge 1 -> key_pressed[0]=1 and one-cycle key_press_pulse[0] at edge 11; release -> key_release_pulse[0] at edge 11 after release.
REQ-029 Bounce: KEY[0] toggles every 3 cycles for 40 cycles, then low -> no pulses during toggling; single press pulse 11 edges after last toggle.
REQ-030 Release glitch: while HELD, KEY[1] high for 5 cycles -> key_pressed[1] stays 1, no release pulse.
REQ-031 Simultaneous: both keys low on same edge -> key_press_pulse=2'b11 in one cycle at edge 11.
REQ-032 Auto-repeat (macro defined): KEY[0] held 60 cycles after acceptance -> pulses at HELD cycles 0, 20, 25, 30 ... 55; macro undefined -> only the first pulse.
